// File: rtl/instruction_ram_loader.sv
// instruction_ram_loader: byte-stream loadable instruction memory with combinational fetch and CPU hold.
module instruction_ram_loader #(
    parameter int          DEPTH     = 64,
    parameter int          ADDR_W    = $clog2(DEPTH),
    parameter logic [31:0] FILL      = 32'hdeadbeef,
    parameter bit          BOOT_HOLD = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     a,
    output logic [31:0]     rd,
    output logic            cpu_hold,
    input  logic            load_en,
    input  logic            load_valid,
    input  logic [7:0]      load_byte,
    output logic            load_ready,
    output logic [ADDR_W:0] load_words,
    output logic            load_overflow
);
    typedef enum logic [1:0] {BOOT, LOAD, RUN} state_t;
    state_t          state_q;
    logic [1:0]      byte_cnt_q;
    logic [23:0]     word_buf_q;
    logic [ADDR_W:0] wr_ptr_q;
    logic            overflow_q;
    logic [31:0]     mem [DEPTH];
    logic            accept, word_done, full, in_range;
    assign load_ready    = (state_q == LOAD) && load_en;
    assign accept        = load_ready && load_valid;
    assign word_done     = accept && (byte_cnt_q == 2'd3);
    assign full          = wr_ptr_q >= (ADDR_W+1)'(DEPTH);
    assign cpu_hold      = state_q != RUN;
    assign load_words    = wr_ptr_q;
    assign load_overflow = overflow_q;
    // Words at or past the write pointer are stale from an earlier session and read as FILL.
    assign in_range      = ((a >> ADDR_W) == 32'd0) && ({1'b0, a[ADDR_W-1:0]} < wr_ptr_q);
    assign rd            = in_range ? mem[a[ADDR_W-1:0]] : FILL;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT_HOLD ? BOOT : RUN;
            byte_cnt_q <= '0;
            word_buf_q <= '0;
            wr_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else if (state_q != LOAD) begin
            if (load_en) begin
                state_q    <= LOAD;
                byte_cnt_q <= '0;
                wr_ptr_q   <= '0;
                overflow_q <= 1'b0;
            end
        end else if (!load_en) begin
            state_q    <= RUN;
            byte_cnt_q <= '0;
        end else if (accept) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            word_buf_q <= {load_byte, word_buf_q[23:8]};
            if (word_done && full)
                overflow_q <= 1'b1;
            else if (word_done)
                wr_ptr_q <= wr_ptr_q + (ADDR_W+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && word_done && !full)
            mem[wr_ptr_q[ADDR_W-1:0]] <= {load_byte, word_buf_q};
    end
endmodule
